// File: rtl/pop_arbiter_if.sv
// Pop-side and output-side handshake bundle for pop_arbiter.
// The master modport is the arbiter's view; the slave modport is the environment's view.
interface pop_arbiter_if #(
  parameter int NUM_PORTS = 4,
  parameter int WIDTH     = 8
);
  localparam int PW = $clog2(NUM_PORTS);

  logic [NUM_PORTS-1:0]       pop_valid;
  logic [NUM_PORTS*WIDTH-1:0] pop_data;
  logic [NUM_PORTS-1:0]       pop_ready;
  logic                       out_valid;
  logic [WIDTH-1:0]           out_data;
  logic [PW-1:0]              out_port;
  logic                       out_ready;

  modport master (
    input  pop_valid, pop_data, out_ready,
    output pop_ready, out_valid, out_data, out_port
  );

  modport slave (
    output pop_valid, pop_data, out_ready,
    input  pop_ready, out_valid, out_data, out_port
  );
endinterface

// File: rtl/pop_arbiter.sv
// Round-robin merge of NUM_PORTS FIFO pop interfaces into one registered output
// stage; one payload per cycle sustained when downstream keeps out_ready high.
module pop_arbiter_lane #(
  parameter int WIDTH = 8
) (
  input  logic             en,
  input  logic             valid,
  input  logic             sel,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic [WIDTH-1:0] masked
);
  // Gating on valid again keeps a pop strobe from ever reaching an empty FIFO.
  assign ready  = en & valid & sel;
  assign masked = ready ? data : '0;
endmodule

module pop_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  pop_arbiter_if.master        bus,
  output logic [CNT_WIDTH-1:0] grant_count
);
  localparam int PW = $clog2(NUM_PORTS);

  typedef enum logic {EMPTY, FULL} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [PW-1:0]    port;
  } hold_t;

  state_t state, state_nxt;
  hold_t  hold;

  logic [PW-1:0]                   ptr, gidx;
  logic [PW:0]                     cand;
  logic                            found, can_accept, en, grant, xfer;
  logic [NUM_PORTS-1:0]            sel, ready;
  logic [NUM_PORTS-1:0][WIDTH-1:0] pdata, masked;
  logic [WIDTH-1:0]                cap_data;

  assign can_accept = (state == EMPTY) || bus.out_ready;
  assign en         = can_accept && !rst;
  assign xfer       = (state == FULL) && bus.out_ready;
  assign grant      = |ready;

  // Walk upward from ptr with wrap; cand never exceeds 2*NUM_PORTS-2.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    cand  = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = {1'b0, ptr} + (PW+1)'(k);
      if (cand >= (PW+1)'(NUM_PORTS)) cand = cand - (PW+1)'(NUM_PORTS);
      if (!found && bus.pop_valid[cand[PW-1:0]]) begin
        found = 1'b1;
        gidx  = cand[PW-1:0];
      end
    end
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_lane
    assign pdata[i] = bus.pop_data[i*WIDTH +: WIDTH];
    assign sel[i]   = found && (gidx == PW'(i));
    pop_arbiter_lane #(.WIDTH(WIDTH)) u_lane (
      .en     (en),
      .valid  (bus.pop_valid[i]),
      .sel    (sel[i]),
      .data   (pdata[i]),
      .ready  (ready[i]),
      .masked (masked[i])
    );
  end

  always_comb begin
    cap_data = '0;
    for (int i = 0; i < NUM_PORTS; i++) cap_data = cap_data | masked[i];
  end

  assign bus.pop_ready = ready;
  assign bus.out_valid = (state == FULL);
  assign bus.out_data  = hold.data;
  assign bus.out_port  = hold.port;

  always_comb begin
    state_nxt = state;
    if (grant)     state_nxt = FULL;
    else if (xfer) state_nxt = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= EMPTY;
      hold        <= '0;
      ptr         <= '0;
      grant_count <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        hold <= '{data: cap_data, port: gidx};
        ptr  <= (gidx == PW'(NUM_PORTS-1)) ? '0 : gidx + PW'(1);
      end
      if (xfer) grant_count <= grant_count + CNT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_pop_arbiter.sv
// Randomized + directed bench for pop_arbiter against a cycle-level behavioural model
// of four upstream FIFOs, a round-robin pointer and a single output holding slot.
module tb_pop_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] grant_count;

  pop_arbiter_if #(.NUM_PORTS(N), .WIDTH(W)) bus ();

  pop_arbiter #(.NUM_PORTS(N), .WIDTH(W), .CNT_WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.master),
    .grant_count (grant_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Model state: what the output slot should hold right now.
  bit          m_full = 1'b0;
  bit          m_zero = 1'b1;
  logic [7:0]  m_data = 8'h00;
  int          m_port = 0;
  int          m_ptr  = 0;
  logic [15:0] m_cnt  = 16'h0;
  logic [5:0]  head [N];
  logic [7:0]  cst  [N];
  bit          seq_mode = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive at negedge, check just after, then advance the model across the next posedge.
  task automatic cyc(input logic r, input logic [N-1:0] v, input logic ordy);
    logic [7:0]   pd [N];
    logic [N-1:0] exp_rdy;
    int           g;
    bit           hit;
    @(negedge clk);
    rst           = r;
    bus.pop_valid = v;
    bus.out_ready = ordy;
    for (int i = 0; i < N; i++) begin
      pd[i] = seq_mode ? {2'(i), head[i]} : cst[i];
      bus.pop_data[i*W +: W] = pd[i];
    end
    #1;
    exp_rdy = '0;
    g       = 0;
    hit     = 1'b0;
    if (!r && (!m_full || ordy)) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (!hit && v[idx]) begin
          hit = 1'b1;
          g   = idx;
          exp_rdy[idx] = 1'b1;
        end
      end
    end
    chk("pop_ready", 32'(bus.pop_ready), 32'(exp_rdy));
    chk("out_valid", 32'(bus.out_valid), 32'(m_full));
    chk("grant_count", 32'(grant_count), 32'(m_cnt));
    if (m_full || m_zero) begin
      chk("out_data", 32'(bus.out_data), 32'(m_data));
      chk("out_port", 32'(bus.out_port), 32'(m_port));
    end
    if (r) begin
      m_full = 1'b0; m_zero = 1'b1; m_data = 8'h00;
      m_port = 0;    m_ptr  = 0;    m_cnt  = 16'h0;
    end else begin
      if (m_full && ordy) m_cnt = m_cnt + 16'h1;
      if (hit) begin
        m_data  = pd[g];
        m_port  = g;
        m_full  = 1'b1;
        m_zero  = 1'b0;
        m_ptr   = (g + 1) % N;
        head[g] = head[g] + 6'h1;
      end else if (m_full && ordy) begin
        m_full = 1'b0;
      end
    end
  endtask

  initial begin
    bus.pop_valid = '0;
    bus.pop_data  = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      head[i] = 6'h0;
      cst[i]  = 8'hA0 + 8'(i);
    end

    // Idle after reset.
    cyc(1'b1, 4'b0000, 1'b0);
    repeat (5) cyc(1'b0, 4'b0000, 1'b1);

    // All ports valid, sustained throughput with A0..A3 payloads.
    repeat (6) cyc(1'b0, 4'b1111, 1'b1);

    // Backpressure holds A0 while other ports wait.
    cyc(1'b1, 4'b0000, 1'b1);
    cyc(1'b0, 4'b0001, 1'b1);
    repeat (3) cyc(1'b0, 4'b0110, 1'b0);
    cyc(1'b0, 4'b0110, 1'b1);
    cyc(1'b0, 4'b0000, 1'b1);

    // Pointer wrap: grant port 2 (ptr->3), then only port 0 valid, then ptr=1 picks port 1.
    cyc(1'b1, 4'b0000, 1'b1);
    cyc(1'b0, 4'b0100, 1'b1);
    cyc(1'b0, 4'b0001, 1'b1);
    cyc(1'b0, 4'b0011, 1'b1);
    cyc(1'b0, 4'b0000, 1'b1);

    // Single port streaming.
    cyc(1'b1, 4'b0000, 1'b1);
    repeat (11) cyc(1'b0, 4'b0100, 1'b1);
    cyc(1'b0, 4'b0000, 1'b1);
    chk("stream_count", 32'(grant_count), 32'd10);

    // Reset while holding 5C discards it; lowest valid port wins afterward.
    for (int i = 0; i < N; i++) cst[i] = 8'h5C;
    cyc(1'b0, 4'b1111, 1'b1);
    cyc(1'b0, 4'b0000, 1'b0);
    cyc(1'b1, 4'b1111, 1'b1);
    cyc(1'b0, 4'b1010, 1'b1);
    cyc(1'b0, 4'b0000, 1'b1);

    // Random traffic with per-port sequence payloads to catch reordering.
    seq_mode = 1'b1;
    for (int n = 0; n < 600; n++)
      cyc(($urandom_range(0, 59) == 0), 4'($urandom), ($urandom_range(0, 3) != 0));
    repeat (4) cyc(1'b0, 4'b0000, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/pop_arbiter.md
POP_ARBITER -- requirements
Module: pop_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 4, SHALL set the number of upstream FIFO pop interfaces served (2..16).
REQ-002 Parameter WIDTH, default 8, SHALL set the payload width of every port.
REQ-003 Parameter CNT_WIDTH, default 16, SHALL set the width of the grant counter.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-006 pop_valid  input  NUM_PORTS  SHALL be the per-port "entry available" flags from upstream FIFOs.
REQ-007 pop_data  input  NUM_PORTS*WIDTH  SHALL carry per-port payloads; port i occupies bits [i*WIDTH +: WIDTH].
REQ-008 pop_ready  output  NUM_PORTS  SHALL be the one-hot-or-zero pop strobe returned to the upstream FIFOs.
REQ-009 out_valid  output  1  SHALL flag a held payload in the output register.
REQ-010 out_data  output  WIDTH  SHALL be the held payload.
REQ-011 out_port  output  clog2(NUM_PORTS)  SHALL be the port index the held payload came from.
REQ-012 out_ready  input  1  SHALL be the downstream accept; transfer occurs when out_valid && out_ready.
REQ-013 grant_count  output  CNT_WIDTH  SHALL count payloads transferred downstream since reset.

Function
REQ-014 The block SHALL use a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-015 can_accept SHALL be (state==EMPTY) || out_ready, computed combinationally.
REQ-016 When can_accept and any pop_valid bit is set, exactly one pop_ready bit SHALL assert in the same cycle, selected round-robin.
REQ-017 pop_ready[i] SHALL never assert while pop_valid[i]=0; upstream FIFOs decrement on pop_ready alone.
REQ-018 Round-robin: search from priority pointer ptr upward with wrap-around; the first set pop_valid bit wins.
REQ-019 After a grant to port g, ptr SHALL become g+1, wrapping to 0 after NUM_PORTS-1; with no grant ptr SHALL hold.
REQ-020 On a grant, out_data, out_port and out_valid=1 SHALL be loaded the following edge (latency 1 cycle from pop_ready to out_valid).
REQ-021 EMPTY->FULL on grant; FULL->FULL on transfer plus grant (back-to-back, one payload per cycle sustained); FULL->EMPTY on transfer without grant; FULL holds without transfer.
REQ-022 While FULL and out_ready=0, out_data and out_port SHALL remain stable and pop_ready SHALL be all-zero.
REQ-023 grant_count SHALL increment by 1 on every downstream transfer and wrap modulo 2^CNT_WIDTH.
REQ-024 Payload from the granted port SHALL be captured unchanged; no reordering within a port.

Reset
REQ-025 While rst=1, on each edge: state=EMPTY, out_valid=0, out_data=0, out_port=0, ptr=0, grant_count=0.
REQ-026 While rst=1, pop_ready SHALL be all-zero regardless of pop_valid.
REQ-027 Reset asserted mid-operation SHALL discard the held payload with no pop_ready pulse in that cycle.

Verification
REQ-028 Reset, then pop_valid=4'b0000 for 5 cycles -> pop_ready=0, out_valid=0, grant_count=0 throughout.
REQ-029 pop_valid=4'b1111 constant, out_ready=1, data port i = 8'hA0+i -> grants 0,1,2,3,0 on consecutive cycles; out_data A0,A1,A2,A3 one cycle later; grant_count=4 after 4 transfers.
REQ-030 Payload A0 held, out_ready=0 for 3 cycles with pop_valid=4'b0110 -> pop_ready=0, out_data=A0 stable; out_ready=1 -> transfer, pop_ready=4'b0010 same cycle.
REQ-031 ptr=3, pop_valid=4'b0001 -> grant port 0 (wrap), ptr becomes 1.
REQ-032 Only port 2 valid, out_ready=1, 10 cycles -> pop_ready[2] every cycle, 10 transfers, out_port=2.
REQ-033 rst=1 while FULL with out_data=8'h5C -> next cycle out_valid=0, grant_count=0, ptr=0; after release first grant goes to lowest valid port.
